// File: rtl/vx_ff_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_ff_arbiter_pkg
// Description : Shared helpers for the round-robin arbiter. It provides the
//               index-width function that sizes the grant index and the
//               round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_ff_arbiter_pkg;

    // Index width for n requesters. A single requester still needs one bit,
    // so that the index ports never collapse to zero width.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_ff_arbiter_find_first.sv
`default_nettype none
// ============================================================================
// Module      : vx_ff_arbiter_find_first
// Description : Lowest-index priority picker. It returns the payload of the
//               lowest set valid bit. The arbiter uses it with index payloads
//               to locate the winning requester.
// Ports       : valid_i [N]         - candidate valid bits
//               data_i  [N*DATAW]   - per-candidate payload, slot 0 in LSBs
//               data_o  [DATAW]     - payload of lowest set candidate (0 if none)
//               valid_o             - any candidate set
// Revision    : 1.0 - initial release
// ============================================================================
module vx_ff_arbiter_find_first #(
    parameter int N     = 4,
    parameter int DATAW = 2
) (
    input  logic [N-1:0]       valid_i,
    input  logic [N*DATAW-1:0] data_i,
    output logic [DATAW-1:0]   data_o,
    output logic               valid_o
);

    // Scan from the top down so that the lowest set index is written last and
    // therefore wins.
    always_comb begin
        data_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                data_o = data_i[i*DATAW +: DATAW];
            end
        end
    end

    assign valid_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/vx_ff_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vx_ff_arbiter
// Description : Round-robin arbiter with a registered (full-flop) output
//               stage. The requester after the most recent grant has the
//               highest priority, and the search wraps around. A winner is
//               loaded whenever the output register is empty or is being
//               drained in the same cycle.
// Ports       : clk        - clock, rising edge
//               reset_n    - asynchronous active-low reset
//               valid_in   [NUM_REQS]       - per-requester request
//               data_in    [NUM_REQS*DATAW] - per-requester payload, req 0 in LSBs
//               ready_in   [NUM_REQS]       - one-hot accept to the winner
//               valid_out  - output register holds a grant
//               data_out   [DATAW]          - granted payload
//               sel_out    [SEL_W]          - granted requester index
//               ready_out  - downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
module vx_ff_arbiter
    import vx_ff_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    localparam int SEL_W   = sel_width(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    input  logic                      ready_out
);

    localparam logic [SEL_W-1:0] c_LAST_RST = SEL_W'(NUM_REQS - 1);

    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] sel_q,  sel_d;
    logic [DATAW-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [NUM_REQS-1:0]       w_masked;
    logic [NUM_REQS*SEL_W-1:0] w_idx_tab;
    logic [SEL_W-1:0]          w_masked_idx, w_first_idx, w_winner;
    logic                      w_masked_any, w_any;
    logic                      w_load;
    logic [DATAW-1:0]          w_payload;

    // Requesters above the last grant form the high-priority window. The
    // index table is the payload that the find-first pickers carry.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
        assign w_masked[i]                   = valid_in[i] & (SEL_W'(i) > last_q);
        assign w_idx_tab[i*SEL_W +: SEL_W]   = SEL_W'(i);
        // Gated by reset_n so that nothing is accepted while reset is held.
        assign ready_in[i] = reset_n & w_load & (w_winner == SEL_W'(i));
    end

    vx_ff_arbiter_find_first #(
        .N     (NUM_REQS),
        .DATAW (SEL_W)
    ) u_ff_masked (
        .valid_i (w_masked),
        .data_i  (w_idx_tab),
        .data_o  (w_masked_idx),
        .valid_o (w_masked_any)
    );

    vx_ff_arbiter_find_first #(
        .N     (NUM_REQS),
        .DATAW (SEL_W)
    ) u_ff_all (
        .valid_i (valid_in),
        .data_i  (w_idx_tab),
        .data_o  (w_first_idx),
        .valid_o (w_any)
    );

    // An empty window means that the pointer sits at or past every active
    // requester, so the search wraps to the lowest active index.
    assign w_winner = w_masked_any ? w_masked_idx : w_first_idx;
    assign w_load   = w_any & (~valid_q | ready_out);

    // Payload mux, indexed by the winner.
    always_comb begin
        w_payload = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_winner == SEL_W'(i)) begin
                w_payload = data_in[i*DATAW +: DATAW];
            end
        end
    end

    always_comb begin
        last_d  = last_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (w_load) begin
            last_d  = w_winner;
            sel_d   = w_winner;
            data_d  = w_payload;
            valid_d = 1'b1;
        end else if (valid_q && ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q  <= c_LAST_RST;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // The outputs come straight from flops, so ready_out has no
    // combinational path to valid_out or data_out.
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sel_out   = sel_q;

endmodule
`default_nettype wire
